// File: rtl/scan_ctrl_138.sv
// scan_ctrl_138: digit scan sequencer for a 3-to-8 active-low decoder driving
// an 8-digit multiplexed display. Each digit gets a blanking gap followed by a
// dwell. Segment data are double-buffered: writes land in a shadow buffer that
// is copied to the active buffer at each frame boundary.
//
// state   | meaning
// IDLE    | scan disabled, decoder off, digit/cnt held at 0
// BLANK   | decoder off for BLANK cycles ahead of the current digit
// SHOW    | decoder on, current digit displayed for DWELL cycles
module scan_ctrl_138 #(
  parameter int DWELL = 1000,
  parameter int BLANK = 16,
  parameter int CW    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [2:0] dec_s,
  output logic [2:0] dec_in,
  output logic [7:0] seg,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [2:0]    DEC_ON     = 3'b100;
  localparam logic [2:0]    DEC_OFF    = 3'b000;

  state_t        state;
  logic [2:0]    digit;
  logic [CW-1:0] cnt;
  logic [7:0]    shadow [8];
  logic [7:0]    active [8];

  state_t        nxt_state;
  logic [2:0]    nxt_digit;
  logic [CW-1:0] nxt_cnt;
  logic          frame_edge;

  // Next-state decode; frame_edge marks the SHOW->BLANK step out of digit 7.
  always_comb begin
    nxt_state  = state;
    nxt_digit  = digit;
    nxt_cnt    = cnt;
    frame_edge = 1'b0;
    if (!en) begin
      nxt_state = ST_IDLE;
      nxt_digit = 3'd0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          nxt_state = ST_BLANK;
          nxt_digit = 3'd0;
          nxt_cnt   = '0;
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            nxt_state = ST_SHOW;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_LAST) begin
            nxt_state  = ST_BLANK;
            nxt_cnt    = '0;
            nxt_digit  = digit + 3'd1;
            frame_edge = (digit == 3'd7);
          end else begin
            nxt_cnt = cnt + CW'(1);
          end
        end
        default: begin
          nxt_state = ST_IDLE;
          nxt_digit = 3'd0;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // State, buffers and registered outputs; outputs are derived from the next
  // state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      digit      <= 3'd0;
      cnt        <= '0;
      dec_s      <= DEC_OFF;
      dec_in     <= 3'd0;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
      wr_ready   <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 8'hFF;
        active[i] <= 8'hFF;
      end
    end else begin
      state      <= nxt_state;
      digit      <= nxt_digit;
      cnt        <= nxt_cnt;
      frame_done <= frame_edge;

      // The copy cycle has wr_ready low, so a shadow write never collides
      // with the frame copy.
      if (frame_edge) begin
        active <= shadow;
      end
      if (wr_en && wr_ready) begin
        shadow[wr_addr] <= wr_data;
      end

      dec_s  <= (nxt_state == ST_SHOW) ? DEC_ON : DEC_OFF;
      dec_in <= (nxt_state == ST_IDLE) ? 3'd0 : nxt_digit;
      // Active only changes on the edge into BLANK, so reading it here for
      // an entry into SHOW is always the value that will be displayed.
      seg    <= (nxt_state == ST_SHOW) ? active[nxt_digit] : 8'hFF;
      // Stall writes during the last SHOW cycle of digit 7 (the copy cycle).
      wr_ready <= !((nxt_state == ST_SHOW) && (nxt_digit == 3'd7) &&
                    (nxt_cnt == DWELL_LAST));
    end
  end

endmodule
